traffic_light_monitor: RTL

- Independent safety checker on the light outputs of the traffic_light controller. It sits between the controller and the lamp drivers.
- Consumes light_highway, light_farm and sensor. Checks encoding, conflicts, sequencing, yellow duration, sensor justification and stalls.
- Passes lights through registered when legal. On the first violation it latches a fault code and forces both roads to RED until cleared.

---
 rtl/traffic_light_monitor.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/traffic_light_monitor.sv
// Safety monitor between the traffic-light controller and the lamp drivers. Legal light pairs
// pass through one register stage; the first violation is latched and both roads forced RED.
module traffic_light_monitor #(
    parameter int unsigned MIN_YELLOW  = 3,
    parameter int unsigned WDOG_CYCLES = 1024,
    parameter int unsigned CNT_W       = 11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] light_highway,
    input  logic [2:0] light_farm,
    input  logic       sensor,
    input  logic       fault_clr,
    output logic [2:0] safe_highway,
    output logic [2:0] safe_farm,
    output logic       fault,
    output logic [2:0] fault_code
);

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    localparam logic [2:0] CODE_NONE     = 3'd0;
    localparam logic [2:0] CODE_ENC      = 3'd1;
    localparam logic [2:0] CODE_CONFLICT = 3'd2;
    localparam logic [2:0] CODE_MOVE     = 3'd3;
    localparam logic [2:0] CODE_SHORT    = 3'd4;
    localparam logic [2:0] CODE_UNJUST   = 3'd5;
    localparam logic [2:0] CODE_STALL    = 3'd6;

    localparam int unsigned       YEL_W     = (MIN_YELLOW < 1) ? 1 : $clog2(MIN_YELLOW + 1);
    localparam logic [YEL_W-1:0]  YEL_MIN   = YEL_W'(MIN_YELLOW);
    localparam logic [CNT_W-1:0]  WDOG_LAST = CNT_W'(WDOG_CYCLES - 1);
    localparam logic [CNT_W-1:0]  WDOG_MAX  = '1;

    typedef enum logic [1:0] {StInit, StRun, StFault} state_e;

    state_e           state_q;
    logic [2:0]       prev_hw_q;
    logic [2:0]       prev_fm_q;
    logic             sensor_q;
    logic [YEL_W-1:0] yel_cnt_hw_q;
    logic [YEL_W-1:0] yel_cnt_fm_q;
    logic [CNT_W-1:0] wdog_cnt_q;

    logic             enc_bad;
    logic             conflict;
    logic             move_bad;
    logic             yel_short;
    logic             farm_unjust;
    logic             changed;
    logic             stall;
    logic [2:0]       init_code;
    logic [2:0]       run_code;
    logic [YEL_W-1:0] yel_cnt_hw_d;
    logic [YEL_W-1:0] yel_cnt_fm_d;
    logic [CNT_W-1:0] wdog_cnt_d;

    function automatic logic is_light(input logic [2:0] l);
        return (l == RED) || (l == YELLOW) || (l == GREEN);
    endfunction

    // Legal moves: hold, G->Y, Y->R, R->G.
    function automatic logic legal_move(input logic [2:0] prv, input logic [2:0] cur);
        return (prv == cur) ||
               ((prv == GREEN)  && (cur == YELLOW)) ||
               ((prv == YELLOW) && (cur == RED)) ||
               ((prv == RED)    && (cur == GREEN));
    endfunction

    function automatic logic [YEL_W-1:0] next_yel(input logic [2:0]       prv,
                                                  input logic [2:0]       cur,
                                                  input logic [YEL_W-1:0] cnt);
        logic [YEL_W-1:0] nxt;
        nxt = '0;
        if (cur == YELLOW) begin
            if (prv != YELLOW) begin
                nxt = YEL_W'(1);
            end else if (cnt < YEL_MIN) begin
                nxt = cnt + YEL_W'(1);
            end else begin
                nxt = cnt;
            end
        end
        return nxt;
    endfunction

    always_comb begin
        enc_bad  = !is_light(light_highway) || !is_light(light_farm);
        conflict = (light_highway != RED) && (light_farm != RED);
        move_bad = !legal_move(prev_hw_q, light_highway) || !legal_move(prev_fm_q, light_farm);

        yel_short = ((prev_hw_q == YELLOW) && (light_highway == RED) &&
                     (yel_cnt_hw_q < YEL_MIN)) ||
                    ((prev_fm_q == YELLOW) && (light_farm == RED) &&
                     (yel_cnt_fm_q < YEL_MIN));

        // Either the current or the previous sensor sample justifies a farm green.
        farm_unjust = (prev_fm_q == RED) && (light_farm == GREEN) && !sensor && !sensor_q;

        changed = (light_highway != prev_hw_q) || (light_farm != prev_fm_q);
        stall   = (wdog_cnt_q == WDOG_LAST) && sensor && !changed;

        init_code = CODE_NONE;
        if (enc_bad) begin
            init_code = CODE_ENC;
        end else if (conflict) begin
            init_code = CODE_CONFLICT;
        end

        run_code = CODE_NONE;
        if (enc_bad) begin
            run_code = CODE_ENC;
        end else if (conflict) begin
            run_code = CODE_CONFLICT;
        end else if (move_bad) begin
            run_code = CODE_MOVE;
        end else if (yel_short) begin
            run_code = CODE_SHORT;
        end else if (farm_unjust) begin
            run_code = CODE_UNJUST;
        end else if (stall) begin
            run_code = CODE_STALL;
        end

        yel_cnt_hw_d = next_yel(prev_hw_q, light_highway, yel_cnt_hw_q);
        yel_cnt_fm_d = next_yel(prev_fm_q, light_farm, yel_cnt_fm_q);

        if (!sensor || changed) begin
            wdog_cnt_d = '0;
        end else if (wdog_cnt_q != WDOG_MAX) begin
            wdog_cnt_d = wdog_cnt_q + CNT_W'(1);
        end else begin
            wdog_cnt_d = wdog_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StInit;
            prev_hw_q    <= RED;
            prev_fm_q    <= RED;
            sensor_q     <= 1'b0;
            yel_cnt_hw_q <= '0;
            yel_cnt_fm_q <= '0;
            wdog_cnt_q   <= '0;
            safe_highway <= RED;
            safe_farm    <= RED;
            fault        <= 1'b0;
            fault_code   <= CODE_NONE;
        end else begin
            sensor_q <= sensor;
            unique case (state_q)
                StInit: begin
                    // Seed the history from the first sample; lamps stay RED this cycle.
                    prev_hw_q    <= light_highway;
                    prev_fm_q    <= light_farm;
                    yel_cnt_hw_q <= YEL_W'(light_highway == YELLOW);
                    yel_cnt_fm_q <= YEL_W'(light_farm == YELLOW);
                    wdog_cnt_q   <= '0;
                    safe_highway <= RED;
                    safe_farm    <= RED;
                    if (init_code != CODE_NONE) begin
                        state_q    <= StFault;
                        fault      <= 1'b1;
                        fault_code <= init_code;
                    end else begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (run_code != CODE_NONE) begin
                        state_q      <= StFault;
                        fault        <= 1'b1;
                        fault_code   <= run_code;
                        safe_highway <= RED;
                        safe_farm    <= RED;
                        yel_cnt_hw_q <= '0;
                        yel_cnt_fm_q <= '0;
                        wdog_cnt_q   <= '0;
                    end else begin
                        safe_highway <= light_highway;
                        safe_farm    <= light_farm;
                        prev_hw_q    <= light_highway;
                        prev_fm_q    <= light_farm;
                        yel_cnt_hw_q <= yel_cnt_hw_d;
                        yel_cnt_fm_q <= yel_cnt_fm_d;
                        wdog_cnt_q   <= wdog_cnt_d;
                    end
                end
                StFault: begin
                    safe_highway <= RED;
                    safe_farm    <= RED;
                    yel_cnt_hw_q <= '0;
                    yel_cnt_fm_q <= '0;
                    wdog_cnt_q   <= '0;
                    if (fault_clr) begin
                        state_q    <= StInit;
                        fault      <= 1'b0;
                        fault_code <= CODE_NONE;
                    end
                end
                default: begin
                    state_q      <= StFault;
                    fault        <= 1'b1;
                    safe_highway <= RED;
                    safe_farm    <= RED;
                end
            endcase
        end
    end

endmodule
